unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port synchronous RAM (1-cycle read latency) between the CPU instruction-fetch port and the data load/store port. Data accesses normally win, with a starvation guard for fetch. Losing requesters get a stall, and read data is routed back to the granted port one cycle later. Sits between PipelinedCPU and a unified memory, replacing the separate instruction/data memories.

Parameters:
ALEN, 32, address width in bits (byte address)
XLEN, 32, data width in bits
MAX_WAIT, 4, consecutive denied fetch cycles after which fetch is forced to win (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held with i_addr stable while i_stall=1
i_addr  in  ALEN  fetch byte address, word aligned
i_stall  out  1  fetch not granted this cycle
i_valid  out  1  i_rdata valid (cycle after fetch grant)
i_rdata  out  32  fetched instruction
d_req  in  1  data request; held stable while d_stall=1
d_we  in  1  1=store, 0=load
d_be  in  4  store byte enables
d_addr  in  ALEN  data byte address
d_wdata  in  XLEN  store data
d_stall  out  1  data not granted this cycle
d_valid  out  1  load data / store ack valid (cycle after data grant)
d_rdata  out  XLEN  load data
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write
mem_be  out  4  RAM byte enables
mem_addr  out  ALEN  RAM byte address
mem_wdata  out  XLEN  RAM write data
mem_rdata  in  XLEN  RAM read data, valid one cycle after mem_en & ~mem_we

Behaviour:
- Reset (async, rst_n=0): owner=OWN_NONE, wait_cnt=0, i_valid=0, d_valid=0. Combinational outputs follow the request rules; mem_en=0 while in reset.
- Grant, combinational, at most one per cycle:
  - force_i = (wait_cnt == MAX_WAIT).
  - gnt_i = i_req & (~d_req | force_i).
  - gnt_d = d_req & ~gnt_i.
- i_stall = i_req & ~gnt_i. d_stall = d_req & ~gnt_d. Both are 0 when the port is not requesting.
- mem_en = gnt_i | gnt_d.
  - On gnt_i: mem_we=0, mem_be=0, mem_addr=i_addr.
  - On gnt_d: mem_we=d_we, mem_be = d_we ? d_be : 0, mem_addr=d_addr, mem_wdata=d_wdata.
  - With no grant: mem_we=0, mem_be=0, mem_addr and mem_wdata are don't-care but driven 0.
- owner register (next edge): OWN_I if gnt_i, OWN_D if gnt_d, else OWN_NONE.
- Response, cycle N+1 after a grant in cycle N:
  - i_valid = (owner==OWN_I), i_rdata = mem_rdata.
  - d_valid = (owner==OWN_D), d_rdata = mem_rdata for loads; for stores d_valid is an ack and d_rdata is don't-care.
  - The unselected rdata output is driven 0.
- Back-to-back: a new grant may issue in N+1 while the N response is delivered, giving full throughput for one requester.
- Starvation counter wait_cnt (4 bits):
  - Increments when i_req & ~gnt_i, saturating at MAX_WAIT.
  - Clears to 0 on gnt_i or when i_req=0.
- Simultaneous requests with force_i=1: fetch wins; data stalls exactly one cycle (the counter clears on that grant).
- Reset mid-operation: the in-flight response is discarded (valid does not assert after reset release). The first grant is possible in the first cycle with rst_n=1.
- Requesters must not change address or data while stalled; the arbiter does not latch requests.
- Misaligned addresses are passed through unchanged; alignment is the CPU's responsibility.

Decomposition:
- riscv_pkg additions: typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} mem_owner_e; constant ARB_MAX_WAIT_DEFAULT = 4. ALEN and XLEN come from riscv_pkg.
- One natural sub-module: arb_starve_ctr (saturating wait counter with force output, parameterised by MAX_WAIT). Everything else stays in unified_mem_arbiter.

Test Plan:
- Fetch only: i_req=1, i_addr=0x00,0x04,0x08 on successive cycles -> mem_en=1 each cycle, i_stall=0, i_valid=1 one cycle later with RAM words 0..2 in order.
- Collision: i_req=1 @0x10, d_req=1 load @0x100 (RAM=0xDEADBEEF) -> cycle N: gnt_d, i_stall=1; N+1: d_valid=1, d_rdata=0xDEADBEEF, fetch granted; N+2: i_valid=1.
- Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0xAABBCCDD over RAM 0x11223344 -> mem_be=0011, d_valid next cycle, later load of 0x200 returns 0x1122CCDD.
- Starvation with MAX_WAIT=4: d_req held 1 and i_req held 1 for 10 cycles -> data granted cycles 0-3, fetch forced in cycle 4 (d_stall=1), data granted cycles 5-8, fetch forced in cycle 9.
- Async reset mid-op: assert rst_n=0 between a load grant and its response -> d_valid stays 0, owner=OWN_NONE, wait_cnt=0; first grant issues in the first cycle after release.
- Idle: both req=0 for 5 cycles -> mem_en=0, stalls=0, valids=0 throughout.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared CPU-side constants and types used by the unified memory arbiter.
package riscv_pkg;

    localparam int unsigned ALEN                 = 32;
    localparam int unsigned XLEN                 = 32;
    localparam int unsigned ARB_MAX_WAIT_DEFAULT = 4;
    localparam int unsigned ARB_CNT_W            = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive denied fetch cycles and raises force_c once MAX_WAIT is reached.
module arb_starve_ctr
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic force_c
);

    logic [ARB_CNT_W-1:0] wait_cnt;
    logic [ARB_CNT_W-1:0] wait_nxt;

    // Clear on grant or idle, otherwise saturate at MAX_WAIT.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!req || gnt) begin
            wait_nxt = '0;
        end else if (wait_cnt != ARB_CNT_W'(MAX_WAIT)) begin
            wait_nxt = wait_cnt + ARB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

    assign force_c = (wait_cnt == ARB_CNT_W'(MAX_WAIT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data load/store.
module unified_mem_arbiter #(
    parameter int unsigned ALEN     = riscv_pkg::ALEN,
    parameter int unsigned XLEN     = riscv_pkg::XLEN,
    parameter int unsigned MAX_WAIT = riscv_pkg::ARB_MAX_WAIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [ALEN-1:0] i_addr,
    output logic            i_stall,
    output logic            i_valid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_stall,
    output logic            d_valid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    import riscv_pkg::*;

    mem_owner_e owner;
    mem_owner_e owner_nxt;
    logic       force_i;
    logic       gnt_i;
    logic       gnt_d;

    arb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (i_req),
        .gnt    (gnt_i),
        .force_c(force_i)
    );

    // Owner remembers who was granted so the RAM's late read data can be routed back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    always_comb begin
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        owner_nxt = OWN_NONE;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;

        gnt_i   = i_req & (~d_req | force_i);
        gnt_d   = d_req & ~gnt_i;
        i_stall = i_req & ~gnt_i;
        d_stall = d_req & ~gnt_d;
        mem_en  = rst_n & (gnt_i | gnt_d);

        if (gnt_i) begin
            owner_nxt = OWN_I;
            mem_addr  = i_addr;
        end else if (gnt_d) begin
            owner_nxt = OWN_D;
            mem_we    = rst_n & d_we;
            mem_be    = d_we ? d_be : 4'b0000;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end

        i_valid = (owner == OWN_I);
        d_valid = (owner == OWN_D);
        i_rdata = i_valid ? mem_rdata : '0;
        d_rdata = d_valid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed plus randomized bench for unified_mem_arbiter with a behavioural RAM and reference model.
module tb_unified_mem_arbiter;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_stall, i_valid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_stall, d_valid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        load_en;
    logic [7:0]  load_idx;
    logic [31:0] load_val;
    logic [31:0] ram    [256];
    logic [31:0] shadow [256];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          starve;
    int          pend_kind;   // 0 none, 1 fetch, 2 data
    bit          pend_store;
    logic [31:0] pend_data;
    bit          last_is, last_ds;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ALEN(32), .XLEN(32), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port RAM with one-cycle read latency and a preload path.
    always @(posedge clk) begin
        if (load_en) begin
            ram[load_idx] <= load_val;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge.
    task automatic step();
        bit gi, gd;
        #1;
        gi = i_req && (!d_req || starve == MW);
        gd = d_req && !gi;
        chk("i_stall", 32'(i_stall), 32'(i_req && !gi));
        chk("d_stall", 32'(d_stall), 32'(d_req && !gd));
        chk("mem_en", 32'(mem_en), 32'(gi || gd));
        if (gi) begin
            chk("mem_addr_i", mem_addr, i_addr);
            chk("mem_we_i", 32'(mem_we), 32'd0);
            chk("mem_be_i", 32'(mem_be), 32'd0);
        end else if (gd) begin
            chk("mem_addr_d", mem_addr, d_addr);
            chk("mem_we_d", 32'(mem_we), 32'(d_we));
            chk("mem_be_d", 32'(mem_be), d_we ? 32'(d_be) : 32'd0);
            if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
        end else begin
            chk("mem_addr_idle", mem_addr, 32'd0);
            chk("mem_wdata_idle", mem_wdata, 32'd0);
            chk("mem_be_idle", 32'(mem_be), 32'd0);
            chk("mem_we_idle", 32'(mem_we), 32'd0);
        end
        chk("i_valid", 32'(i_valid), 32'(pend_kind == 1));
        chk("d_valid", 32'(d_valid), 32'(pend_kind == 2));
        chk("i_rdata", i_rdata, (pend_kind == 1) ? pend_data : 32'd0);
        if (pend_kind == 2 && !pend_store) chk("d_rdata", d_rdata, pend_data);
        if (pend_kind != 2) chk("d_rdata_zero", d_rdata, 32'd0);
        last_is = i_req && !gi;
        last_ds = d_req && !gd;

        @(posedge clk);
        pend_kind  = 0;
        pend_store = 0;
        if (gi) begin
            pend_kind = 1;
            pend_data = shadow[i_addr[9:2]];
        end else if (gd) begin
            pend_kind  = 2;
            pend_store = d_we;
            pend_data  = shadow[d_addr[9:2]];
            if (d_we)
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) shadow[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end
        starve = (!i_req || gi) ? 0 : ((starve < int'(MW)) ? starve + 1 : int'(MW));
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        load_en  = 1'b1;
        load_idx = 8'(idx);
        load_val = val;
        shadow[idx] = val;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        load_en = 1'b0; load_idx = '0; load_val = '0;
        starve = 0; pend_kind = 0; pend_store = 0; pend_data = '0;
        last_is = 0; last_ds = 0;

        @(negedge clk);
        #1;
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);

        for (int k = 0; k < 256; k++) begin
            logic [31:0] v;
            v = $urandom;
            if (k < 3) v = 32'h1000_0000 + 32'(k);
            if (k == 64) v = 32'hDEAD_BEEF;
            if (k == 128) v = 32'h1122_3344;
            preload(k, v);
        end
        load_en = 1'b0;
        rst_n   = 1'b1;

        // Fetch only, back-to-back
        i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 32'(k * 4);
            step();
        end
        chk("fetch_w2", i_rdata, 32'h1000_0002);
        i_req = 1'b0;
        step();

        // Collision: data wins, fetch follows
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        step();
        chk("coll_d_valid", 32'(d_valid), 32'd1);
        chk("coll_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();
        i_req = 1'b0;
        step();

        // Partial store then read back
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hAABB_CCDD;
        step();
        d_we = 1'b0;
        step();
        d_req = 1'b0;
        chk("store_merge", d_rdata, 32'h1122_CCDD);
        step();

        // Starvation guard: fetch forced every fifth cycle
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("starve_pat", 32'(i_stall), (c % 5 == 4) ? 32'd0 : 32'd1);
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Async reset between a load grant and its response
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("in_rst_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_drop_d_valid", 32'(d_valid), 32'd0);
        chk("rst_drop_i_valid", 32'(i_valid), 32'd0);
        starve = 0; pend_kind = 0; pend_store = 0;
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h30;
        step();
        d_req = 1'b0;
        step();
        i_req = 1'b0;
        step();

        // Idle
        for (int c = 0; c < 5; c++) step();

        // Randomized traffic; stalled requesters hold their request
        last_is = 0; last_ds = 0;
        for (int c = 0; c < 400; c++) begin
            if (!last_is) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!last_ds) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom);
                d_addr  = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
            end
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
